// File: rtl/eq_sweep_checker.sv
// Exhaustive truth-table sweep: drives every input vector to an expression pair,
// samples both outputs after a settle window and tallies mismatches.
module eq_sweep_checker #(
  parameter int NVARS  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [NVARS-1:0] vec,
  input  logic             f_orig,
  input  logic             f_simp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NVARS:0]   err_count,
  output logic [NVARS-1:0] first_bad,
  output logic             first_bad_valid
);
  localparam int NVEC  = 1 << NVARS;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [NVARS-1:0] VEC_LAST = NVARS'(NVEC - 1);
  localparam logic [NVARS:0]   ERR_MAX  = (NVARS+1)'(NVEC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [NVARS-1:0] vec_nx, first_bad_nx;
  logic [NVARS:0]   err_count_nx;
  logic             busy_nx, done_nx, first_bad_valid_nx;

  function automatic logic [NVARS:0] sat_inc(input logic [NVARS:0] v);
    return (v >= ERR_MAX) ? ERR_MAX : v + 1'b1;
  endfunction

  always_comb begin
    state_nx           = state;
    cnt_nx             = cnt;
    vec_nx             = vec;
    busy_nx            = busy;
    done_nx            = done;
    err_count_nx       = err_count;
    first_bad_nx       = first_bad;
    first_bad_valid_nx = first_bad_valid;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx           = DRIVE;
          cnt_nx             = '0;
          vec_nx             = '0;
          busy_nx            = 1'b1;
          done_nx            = 1'b0;
          err_count_nx       = '0;
          first_bad_nx       = '0;
          first_bad_valid_nx = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          state_nx = SAMPLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SAMPLE: begin
        if (f_orig != f_simp) begin
          err_count_nx = sat_inc(err_count);
          if (!first_bad_valid) begin
            first_bad_nx       = vec;
            first_bad_valid_nx = 1'b1;
          end
        end
        // The last vector is kept on the bus so the result can be inspected.
        if (vec == VEC_LAST) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          state_nx = DRIVE;
          vec_nx   = vec + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_count       <= '0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      vec             <= vec_nx;
      busy            <= busy_nx;
      done            <= done_nx;
      err_count       <= err_count_nx;
      first_bad       <= first_bad_nx;
      first_bad_valid <= first_bad_valid_nx;
    end
  end

  assign pass = done && (err_count == '0);

endmodule

// File: doc/eq_sweep_checker.md
Name: eq_sweep_checker

Overview:
- Exhaustive truth-table sweep engine for the Boolean-simplification exercises.
- Drives every input combination onto the shared input bus of an expression/simplified-expression module pair, samples both outputs, and counts mismatches.
- Latches the first failing vector and reports pass/fail. Replaces hand-written #delay stimulus sequences with a clocked, self-checking stage.

Parameters:
- NVARS, 2, number of Boolean input variables; sweep covers 2^NVARS vectors (1..8 supported).
- SETTLE, 1, cycles each vector is held before sampling (>=1).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- vec  output  NVARS  current input vector to the function pair; bit NVARS-1 = x (MSB), bit 0 = last variable.
- f_orig  input  1  output of the unsimplified expression.
- f_simp  input  1  output of the simplified expression.
- busy  output  1  high while sweeping.
- done  output  1  high in DONE, held until next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  NVARS+1  number of mismatching vectors, saturates at 2^NVARS.
- first_bad  output  NVARS  vec of first mismatch.
- first_bad_valid  output  1  first_bad holds a real mismatch.

Behaviour:
- One clock, synchronous active-low reset. Reset is sampled on the rising clk edge when rst_n=0.
- Reset values: state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_bad=0, first_bad_valid=0, settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 -> DRIVE next edge; vec=0, err_count/first_bad/first_bad_valid cleared, busy=1.
  - Otherwise stay in IDLE.
- DRIVE:
  - Hold vec for SETTLE cycles (counter 0..SETTLE-1), then go to SAMPLE.
  - start is ignored.
- SAMPLE (1 cycle):
  - At the closing edge, mismatch = (f_orig != f_simp).
  - On mismatch: err_count+1. If first_bad_valid=0, latch first_bad=vec and set first_bad_valid=1.
  - If vec == 2^NVARS-1 -> DONE (busy=0, done=1); vec holds its final value, with no wrap to 0.
  - Else vec+1 -> DRIVE.
- DONE:
  - Outputs held stable.
  - start=1 -> DRIVE with the same clearing as from IDLE (back-to-back sweeps allowed).
- Timing: vector k is applied from the cycle after start + k*(SETTLE+1). Total busy cycles = 2^NVARS*(SETTLE+1).
- Ordering: vectors ascend 0..2^NVARS-1 (for NVARS=2: 00,01,10,11 as x y).
- pass is combinational from done and err_count; all other outputs are registered.
- Reset mid-sweep: immediate return to reset values. A partial result is never reported as done.
- start held high through a sweep: no effect until DONE. At DONE a new sweep begins on the next edge, so done stays high for exactly one cycle.
- f_orig/f_simp must be combinational functions of vec only; no handshake on them.

Test Plan:
- NVARS=2, SETTLE=1, f_orig=x&~(~x|y), f_simp=x&~y: pulse start.
  - busy for 8 cycles, vec 00,01,10,11 each 2 cycles.
  - Then done=1, pass=1, err_count=0, first_bad_valid=0.
- Same, faulty f_simp=x|~y:
  - Mismatches at 00 and 11.
  - err_count=2, first_bad=2'b00, first_bad_valid=1, pass=0.
- f_orig=1, f_simp=0 (all fail), NVARS=3, SETTLE=2:
  - Busy 24 cycles, err_count=8, first_bad=3'b000.
  - vec ends at 3'b111 and holds in DONE.
- Assert start repeatedly while busy:
  - Sweep timing and counts identical to the single-pulse case.
  - After done, start clears err_count to 0 and restarts at vec=0.
- rst_n=0 for one cycle while vec=2'b10 with one error already counted:
  - Next cycle all outputs are at reset values, state=IDLE.
  - A later start gives a clean full sweep.
- SETTLE=3, mismatch only at vec=01:
  - Comparison taken on the 4th cycle of vec=01.
  - err_count=1, first_bad=2'b01.
